// File: rtl/load_read_unit.sv
// Load read unit: accepts one load at a time, issues a word-aligned memory read,
// extracts and extends the addressed byte/halfword/word, and returns it over valid/ready.
module load_read_unit #(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [3:0]  count;
   logic        misaligned;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] ext_data;

   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = (req_addr[1:0] != 2'b00);
         2'b11:   misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   // The read strobe is combinational so memory sees it in the acceptance cycle;
   // clr_n gating keeps it quiet while reset holds the FSM in IDLE.
   assign mem_rd_en = clr_n && (state == IDLE) && req_valid && !misaligned;
   assign mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      lane_byte = mem_rdata[7:0];
      case (off_q)
         2'd0:    lane_byte = mem_rdata[7:0];
         2'd1:    lane_byte = mem_rdata[15:8];
         2'd2:    lane_byte = mem_rdata[23:16];
         default: lane_byte = mem_rdata[31:24];
      endcase
      lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'b00:   ext_data = {{24{signed_q & lane_byte[7]}}, lane_byte};
         2'b01:   ext_data = {{16{signed_q & lane_half[15]}}, lane_half};
         default: ext_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= 32'd0;
         off_q     <= 2'd0;
         size_q    <= 2'd0;
         signed_q  <= 1'b0;
         count     <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  off_q     <= req_addr[1:0];
                  size_q    <= req_size;
                  signed_q  <= req_signed;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (misaligned) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= 32'd0;
                     state     <= RESP;
                  end else begin
                     count <= 4'(READ_LATENCY);
                     state <= WAIT;
                  end
               end
            end
            // Data is valid in the cycle the counter reaches 1.
            WAIT: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  rsp_data  <= ext_data;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_read_unit.sv
// Scoreboard bench for load_read_unit: instance a uses READ_LATENCY=1, instance b uses 3;
// stimulus pushes expected responses, per-instance monitors pop and compare.
module tb_load_read_unit;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic        rsp_ready = 1'b1;
   logic        req_ready_a, req_ready_b, mem_rd_en_a, mem_rd_en_b;
   logic [31:0] mem_addr_a, mem_addr_b, mem_rdata_a, mem_rdata_b;
   logic        rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b, busy_a, busy_b;
   logic [31:0] rsp_data_a, rsp_data_b;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] mem_word = 32'd0;
   logic [3:0]  pipe_a = 4'd0, pipe_b = 4'd0;
   int          rd_cnt_a = 0, rd_cnt_b = 0, exp_rd_a = 0, exp_rd_b = 0;

   always #5 clk = ~clk;

   load_read_unit #(.READ_LATENCY(1), .ADDR_W(32)) dut_a (
      .clk(clk), .clr_n(clr_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a),
      .rsp_err(rsp_err_a), .busy(busy_a));

   load_read_unit #(.READ_LATENCY(3), .ADDR_W(32)) dut_b (
      .clk(clk), .clr_n(clr_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b),
      .rsp_err(rsp_err_b), .busy(busy_b));

   // Memory model: data is only valid exactly READ_LATENCY cycles after the strobe.
   always @(posedge clk) begin
      pipe_a <= {pipe_a[2:0], mem_rd_en_a};
      pipe_b <= {pipe_b[2:0], mem_rd_en_b};
      if (mem_rd_en_a) rd_cnt_a++;
      if (mem_rd_en_b) rd_cnt_b++;
   end

   assign mem_rdata_a = pipe_a[0] ? mem_word : 32'hA5A5_A5A5;
   assign mem_rdata_b = pipe_b[2] ? mem_word : 32'hA5A5_A5A5;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (clr_n && rsp_valid_a) begin
         if (q_a.size() == 0) checkOutput("a_unexpected_rsp", {31'd0, rsp_valid_a}, 32'd0);
         else begin
            checkOutput("a_rsp_data", rsp_data_a, q_a[0].data);
            checkOutput("a_rsp_err", {31'd0, rsp_err_a}, {31'd0, q_a[0].err});
            if (rsp_ready) void'(q_a.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (clr_n && rsp_valid_b) begin
         if (q_b.size() == 0) checkOutput("b_unexpected_rsp", {31'd0, rsp_valid_b}, 32'd0);
         else begin
            checkOutput("b_rsp_data", rsp_data_b, q_b[0].data);
            checkOutput("b_rsp_err", {31'd0, rsp_err_b}, {31'd0, q_b[0].err});
            if (rsp_ready) void'(q_b.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit sel, input logic [31:0] addr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] word,
                                input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      e.data = exp_data;
      e.err  = exp_err;
      mem_word   = word;
      req_addr   = addr;
      req_size   = size;
      req_signed = sgn;
      if (sel) begin q_b.push_back(e); req_valid_b = 1'b1; end
      else     begin q_a.push_back(e); req_valid_a = 1'b1; end
      if (!exp_err) begin
         if (sel) exp_rd_b++; else exp_rd_a++;
      end
      #1;
      checkOutput("rd_en_at_accept", {31'd0, sel ? mem_rd_en_b : mem_rd_en_a}, {31'd0, !exp_err});
      if (!exp_err) checkOutput("mem_addr", sel ? mem_addr_b : mem_addr_a, {addr[31:2], 2'b00});
      tick();
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      checkOutput("rd_en_after_accept", {31'd0, sel ? mem_rd_en_b : mem_rd_en_a}, 32'd0);
   endtask

   task automatic waitResponse(input bit sel, input int exp_lat);
      int n = 1;
      while (!(sel ? rsp_valid_b : rsp_valid_a) && n < 50) begin
         tick();
         n++;
      end
      checkOutput("rsp_latency", n, exp_lat);
   endtask

   task automatic waitIdle(input bit sel);
      int n = 0;
      while (!(sel ? req_ready_b : req_ready_a) && n < 50) begin
         tick();
         n++;
      end
      checkOutput("return_to_idle", {31'd0, sel ? req_ready_b : req_ready_a}, 32'd1);
   endtask

   task automatic runLoad(input bit sel, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] word,
                          input logic [31:0] exp_data, input logic exp_err);
      applyStimulus(sel, addr, size, sgn, word, exp_data, exp_err);
      waitResponse(sel, exp_err ? 1 : (sel ? 4 : 2));
      waitIdle(sel);
   endtask

   initial begin
      req_valid_a = 1'b1;
      req_addr    = 32'h100;
      req_size    = 2'b10;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rd_en", {31'd0, mem_rd_en_a}, 32'd0);
      checkOutput("reset_req_ready", {31'd0, req_ready_a}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy_a}, 32'd0);
      checkOutput("reset_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
      checkOutput("reset_rsp_data", rsp_data_a, 32'd0);
      checkOutput("reset_rsp_err", {31'd0, rsp_err_a}, 32'd0);
      checkOutput("reset_b_busy", {31'd0, busy_b}, 32'd0);
      req_valid_a = 1'b0;
      #2 clr_n = 1'b1;
      tick();

      runLoad(0, 32'h100, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
      runLoad(0, 32'h103, 2'b00, 1'b1, 32'h8012_3456, 32'hFFFF_FF80, 1'b0);
      runLoad(0, 32'h103, 2'b00, 1'b0, 32'h8012_3456, 32'h0000_0080, 1'b0);
      runLoad(0, 32'h201, 2'b00, 1'b0, 32'h1234_5678, 32'h0000_0056, 1'b0);
      runLoad(0, 32'h202, 2'b01, 1'b1, 32'h7FFF_8000, 32'h0000_7FFF, 1'b0);
      runLoad(0, 32'h202, 2'b01, 1'b1, 32'h8001_0000, 32'hFFFF_8001, 1'b0);
      runLoad(0, 32'h300, 2'b01, 1'b1, 32'h1234_F00D, 32'hFFFF_F00D, 1'b0);
      runLoad(0, 32'h101, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);
      runLoad(0, 32'h100, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);
      runLoad(0, 32'h203, 2'b01, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);

      // Backpressure on the latency-3 instance with a second request waiting.
      rsp_ready = 1'b0;
      applyStimulus(1, 32'h400, 2'b10, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
      waitResponse(1, 4);
      mem_word    = 32'h9ABC_1234;
      req_addr    = 32'h406;
      req_size    = 2'b01;
      req_signed  = 1'b0;
      req_valid_b = 1'b1;
      q_b.push_back('{data: 32'h0000_9ABC, err: 1'b0});
      exp_rd_b++;
      for (int i = 0; i < 4; i++) begin
         checkOutput("stall_busy", {31'd0, busy_b}, 32'd1);
         checkOutput("stall_req_ready", {31'd0, req_ready_b}, 32'd0);
         checkOutput("stall_rd_en", {31'd0, mem_rd_en_b}, 32'd0);
         checkOutput("stall_rsp_valid", {31'd0, rsp_valid_b}, 32'd1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      checkOutput("post_hs_rsp_valid", {31'd0, rsp_valid_b}, 32'd0);
      checkOutput("post_hs_req_ready", {31'd0, req_ready_b}, 32'd1);
      checkOutput("post_hs_rd_en", {31'd0, mem_rd_en_b}, 32'd1);
      checkOutput("post_hs_mem_addr", mem_addr_b, 32'h404);
      tick();
      req_valid_b = 1'b0;
      waitResponse(1, 4);
      waitIdle(1);

      // Reset while waiting on memory: the request must vanish without a response.
      applyStimulus(1, 32'h500, 2'b10, 1'b0, 32'h1111_1111, 32'h1111_1111, 1'b0);
      tick();
      clr_n = 1'b0;
      #1;
      void'(q_b.pop_back());
      checkOutput("abort_busy", {31'd0, busy_b}, 32'd0);
      checkOutput("abort_req_ready", {31'd0, req_ready_b}, 32'd1);
      checkOutput("abort_rsp_valid", {31'd0, rsp_valid_b}, 32'd0);
      checkOutput("abort_rsp_data", rsp_data_b, 32'd0);
      tick();
      clr_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checkOutput("abort_no_rsp", {31'd0, rsp_valid_b}, 32'd0);
         tick();
      end
      runLoad(1, 32'h501, 2'b00, 1'b1, 32'h0000_FF00, 32'hFFFF_FFFF, 1'b0);

      repeat (3) tick();
      checkOutput("a_rd_strobes", rd_cnt_a, exp_rd_a);
      checkOutput("b_rd_strobes", rd_cnt_b, exp_rd_b);
      checkOutput("a_queue_drained", q_a.size(), 32'd0);
      checkOutput("b_queue_drained", q_b.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/load_read_unit.md
Name: load_read_unit

Overview:
- Read-side companion to the processor's enable-gated register/memory storage. It accepts one load request at a time from the memory stage and issues a word-aligned read to synchronous data memory with fixed latency.
- It extracts the addressed byte, halfword or word, sign- or zero-extends it, and returns it over a valid/ready response handshake.
- Misaligned requests are rejected without touching memory. The pipeline stalls on busy.

Parameters:
- READ_LATENCY, 1, cycles from the mem_rd_en cycle to valid mem_rdata (legal range 1..15).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- mem_rd_en  out  1  one-cycle read strobe to memory.
- mem_addr  out  ADDR_W  word address: req_addr with bits [1:0] forced to 0.
- mem_rdata  in  32  memory read data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  extended load result.
- rsp_err  out  1  misaligned or illegal request.
- busy  out  1  state != IDLE (pipeline stall).

Behaviour:
- Reset is asynchronous and active-low on clr_n.
  - While clr_n = 0: state = IDLE, rsp_valid/rsp_err/busy = 0, rsp_data = 0, internal offset/size/signed/counter = 0.
  - mem_rd_en is forced to 0 while clr_n = 0, regardless of req_valid.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Acceptance occurs on a clock edge with req_valid = 1.
  - Misaligned is defined as: size 01 with addr[0] = 1; size 10 with addr[1:0] != 0; or size 11.
  - Misaligned request: go to RESP with rsp_err = 1 and rsp_data = 0. mem_rd_en stays 0.
  - Aligned request: in the acceptance cycle, mem_rd_en = 1 combinationally and mem_addr = {addr[ADDR_W-1:2], 00}. Latch addr[1:0], size and signed. Load the counter with READ_LATENCY. Go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 1, capture the extended mem_rdata into rsp_data, clear rsp_err and go to RESP.
  - mem_rd_en = 0 throughout WAIT.
- RESP:
  - rsp_valid = 1. rsp_data and rsp_err are held stable until rsp_ready = 1.
  - On handshake, go to IDLE. No request is accepted in the same cycle.
  - rsp_valid deasserts in the cycle after the handshake.
- Timing:
  - rsp_valid is first high READ_LATENCY+1 cycles after the acceptance edge.
  - Minimum request spacing is READ_LATENCY+2 cycles.
- Byte-lane extraction is little-endian.
  - Byte: lane = mem_rdata[8*off+7 : 8*off].
  - Half: mem_rdata[15:0] when off = 0, mem_rdata[31:16] when off = 2.
  - Word: mem_rdata passes through unchanged.
  - Extension fills upper bits with the lane MSB if signed = 1, else with 0.
- req_* inputs are ignored outside IDLE. Changes to them after acceptance have no effect.
- busy = 1 in WAIT and RESP, including during a misaligned-error RESP.
- Reset mid-operation (WAIT or RESP) aborts immediately:
  - Any pending memory data is discarded.
  - rsp_valid drops asynchronously and no response is issued for the aborted request.

Test Plan:
- Reset then word load: READ_LATENCY = 1, addr 0x100, size 10, mem_rdata 0xDEADBEEF.
  - Expect mem_rd_en high one cycle with mem_addr 0x100.
  - Expect rsp_valid at cycle 2, rsp_data 0xDEADBEEF, rsp_err 0.
- Signed byte: addr 0x103, size 00, signed 1, mem_rdata 0x80123456 -> rsp_data 0xFFFFFF80. Same load with signed 0 -> 0x00000080.
- Halfword upper lane: addr 0x202, size 01, signed 1, mem_rdata 0x7FFF8000 -> rsp_data 0x00007FFF.
  - Same address with mem_rdata 0x8001_0000 -> 0xFFFF8001.
- Misaligned and illegal requests:
  - Word at 0x101 -> no mem_rd_en, rsp_err 1, rsp_data 0, rsp_valid next cycle.
  - Size 11 at 0x100 -> same response.
- Backpressure and latency: READ_LATENCY = 3, rsp_ready held low 4 cycles.
  - rsp_valid first high 4 cycles after acceptance.
  - rsp_data stable while stalled; busy = 1; req_ready = 0.
  - Second request presented during the stall is not accepted until after the handshake.
- Reset mid-WAIT: assert clr_n = 0 one cycle after acceptance.
  - State returns to IDLE; rsp_valid never asserts.
  - After release, a new load completes normally.
